// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 bus bridge.
// The FSM states, the sampled pin bundle and the default interrupt vector live here.
package z80_bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MEM  = 3'd1,
    IO   = 3'd2,
    INTA = 3'd3,
    HOLD = 3'd4
  } busState_t;

  typedef struct packed {
    logic        nM1;
    logic        nMreq;
    logic        nIorq;
    logic        nRd;
    logic        nWr;
    logic        nRfsh;
    logic [15:0] addr;
    logic [7:0]  data;
  } z80Pins_t;

  localparam logic [7:0] DEFAULT_VECTOR = 8'hFF;
  localparam int         TIMER_WIDTH    = 8;

  // Strobes come out of reset inactive so the FSM sees no access at all.
  localparam z80Pins_t PINS_IDLE = '{
    nM1: 1'b1, nMreq: 1'b1, nIorq: 1'b1, nRd: 1'b1, nWr: 1'b1, nRfsh: 1'b1,
    addr: 16'h0000, data: 8'h00
  };

  function automatic logic isAccess(input z80Pins_t pins);
    return !pins.nRd || !pins.nWr;
  endfunction

endpackage

// File: rtl/z80_pin_sync.sv
// Single registered sampling stage for the Z80 control pins, address and data.
module z80_pin_sync
  import z80_bus_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  z80Pins_t pinsIn,
  output z80Pins_t pinsOut
);

  always_ff @(posedge clock) begin
    if (reset) begin
      pinsOut <= PINS_IDLE;
    end else begin
      pinsOut <= pinsIn;
    end
  end

endmodule

// File: rtl/z80_bus_bridge.sv
// Bridges the Z80 active-low bus onto request/acknowledge memory and I/O ports,
// issuing one request per Z80 access and stretching it with WAIT until acknowledged.
module z80_bus_bridge
  import z80_bus_pkg::*;
#(
  parameter logic [7:0] IM_VECTOR   = DEFAULT_VECTOR,
  parameter int         ACK_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        n_m1,
  input  logic        n_mreq,
  input  logic        n_iorq,
  input  logic        n_rd,
  input  logic        n_wr,
  input  logic        n_rfsh,
  input  logic [15:0] a,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic        n_wait,
  output logic        mem_req,
  output logic        mem_we,
  output logic        io_req,
  output logic        io_we,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic        mem_ack,
  input  logic        io_ack,
  input  logic [7:0]  mem_rdata,
  input  logic [7:0]  io_rdata,
  output logic        timeout
);

  z80Pins_t rawPins;
  z80Pins_t syncPins;

  assign rawPins = '{
    nM1: n_m1, nMreq: n_mreq, nIorq: n_iorq, nRd: n_rd, nWr: n_wr, nRfsh: n_rfsh,
    addr: a, data: d_in
  };

  z80_pin_sync pinSync (
    .clock   (clock),
    .reset   (reset),
    .pinsIn  (rawPins),
    .pinsOut (syncPins)
  );

  busState_t              stateReg, stateNext;
  logic [TIMER_WIDTH-1:0] cntReg, cntNext;
  logic [7:0]             dOutNext, busWdataNext;
  logic [15:0]            busAddrNext;
  logic                   dOeNext, nWaitNext, memReqNext, memWeNext;
  logic                   ioReqNext, ioWeNext, timeoutNext;

  logic ackHit, timeoutHit, isWrite;
  logic [7:0] ackData;

  // Only the ack matching the current access type counts; anything else is ignored.
  assign ackHit     = (stateReg == MEM && mem_ack) || (stateReg == IO && io_ack);
  assign ackData    = (stateReg == IO) ? io_rdata : mem_rdata;
  assign isWrite    = (stateReg == IO) ? io_we : mem_we;
  assign timeoutHit = (ACK_TIMEOUT != 0) && (cntReg == TIMER_WIDTH'(ACK_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (!syncPins.nIorq && !syncPins.nM1) begin
          stateNext = INTA;
        end else if (!syncPins.nMreq && syncPins.nRfsh && isAccess(syncPins)) begin
          stateNext = MEM;
        end else if (!syncPins.nIorq && syncPins.nM1 && isAccess(syncPins)) begin
          stateNext = IO;
        end
      end
      MEM, IO: begin
        if (ackHit || timeoutHit) begin
          stateNext = HOLD;
        end
      end
      INTA: stateNext = HOLD;
      HOLD: begin
        if (syncPins.nRd && syncPins.nWr && syncPins.nIorq) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    dOutNext     = d_out;
    dOeNext      = d_oe;
    nWaitNext    = n_wait;
    memReqNext   = mem_req;
    memWeNext    = mem_we;
    ioReqNext    = io_req;
    ioWeNext     = io_we;
    busAddrNext  = bus_addr;
    busWdataNext = bus_wdata;
    timeoutNext  = 1'b0;
    cntNext      = cntReg + TIMER_WIDTH'(1);
    case (stateReg)
      IDLE: begin
        cntNext = '0;
        if (stateNext == MEM || stateNext == IO) begin
          // Both strobes low is illegal; it decodes as a write.
          memReqNext   = (stateNext == MEM);
          memWeNext    = (stateNext == MEM) && !syncPins.nWr;
          ioReqNext    = (stateNext == IO);
          ioWeNext     = (stateNext == IO) && !syncPins.nWr;
          nWaitNext    = 1'b0;
          busAddrNext  = syncPins.addr;
          busWdataNext = syncPins.data;
        end else if (stateNext == INTA) begin
          dOutNext = IM_VECTOR;
          dOeNext  = 1'b1;
        end
      end
      MEM, IO: begin
        if (ackHit || timeoutHit) begin
          memReqNext  = 1'b0;
          memWeNext   = 1'b0;
          ioReqNext   = 1'b0;
          ioWeNext    = 1'b0;
          nWaitNext   = 1'b1;
          timeoutNext = !ackHit;
          if (!isWrite) begin
            dOutNext = ackHit ? ackData : 8'hFF;
            dOeNext  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (stateNext == IDLE) begin
          dOeNext = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cntReg    <= '0;
      d_out     <= 8'h00;
      d_oe      <= 1'b0;
      n_wait    <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      io_req    <= 1'b0;
      io_we     <= 1'b0;
      bus_addr  <= 16'h0000;
      bus_wdata <= 8'h00;
      timeout   <= 1'b0;
    end else begin
      cntReg    <= cntNext;
      d_out     <= dOutNext;
      d_oe      <= dOeNext;
      n_wait    <= nWaitNext;
      mem_req   <= memReqNext;
      mem_we    <= memWeNext;
      io_req    <= ioReqNext;
      io_we     <= ioWeNext;
      bus_addr  <= busAddrNext;
      bus_wdata <= busWdataNext;
      timeout   <= timeoutNext;
    end
  end

endmodule
